irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Memory-mapped interrupt controller that sits downstream of the timer and other peripherals. It collects their level-sensitive interrupt requests and masks them per source and globally. It then presents one prioritised request with a vector to the CPU and tracks the request through an acknowledge / end-of-interrupt (EOI) handshake. It uses the same single-cycle peripheral bus as the other memory-mapped blocks.

## Interface
- NSRC, 4, number of interrupt sources (1..8); source 0 is the timer
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- sel  in  1  bus select for this block
- we  in  1  bus write strobe
- re  in  1  bus read strobe
- addr  in  2  register index
- wdata  in  16  bus write data
- rdata  out  16  bus read data, combinational
- rdy  out  1  equals sel; single-cycle access
- src_irq  in  NSRC  peripheral requests, level, active-high (e.g. timer int_req)
- cpu_irq  out  1  request to CPU, registered
- cpu_ack  in  1  CPU acknowledge, single-cycle pulse expected
- cpu_vec  out  3  index of the source being requested/serviced, registered

## Operation
- Register map:
  - 00 IE (rw): bits[NSRC-1:0] per-source enable; reset 0.
  - 01 GCR (rw): bit0 GIE; reset 0.
  - 10 STAT (ro): [NSRC-1:0] pend_q; [10:8] cur vector; [13:12] FSM state (00 IDLE, 01 REQ, 10 SVC).
  - 11 EOI (wo): any write ends service; reads return 0.
  - Unused bits read 0. Writes to STAT are ignored.
- rdata = 0 when !sel or !re.
- pend_q: register, pend_q <= src_irq & IE every cycle; reset 0.
- Priority: lowest set index of pend_q wins. The vector width is 3 regardless of NSRC.
- FSM:
  - IDLE: if GIE && |pend_q, go to REQ and latch cur vector = winning index.
  - REQ: if cpu_ack, go to SVC. Else if !GIE or pend_q[cur] == 0 (withdrawn/masked), go to IDLE. Else hold.
  - SVC: on a bus write to EOI, go to IDLE. Otherwise hold; GIE/IE changes are ignored.
  - No nesting. A higher-priority source arriving in REQ does not change cur.
- cpu_irq registered = (next state == REQ). It is high exactly while the state is REQ.
- cpu_vec registered; it holds cur through REQ and SVC and keeps its last value in IDLE.
- Reset values: cpu_irq=0, cpu_vec=0, state=IDLE, pend_q=0, IE=0, GIE=0. rdata=0 while unselected.

## Timing
- Source rises before edge E0: pend_q set after E0; REQ entered and cpu_irq=1 after E1. This is 2 cycles latency from the sampled level.
- cpu_ack sampled at edge Ea while in REQ: state=SVC and cpu_irq=0 after Ea.
- EOI write at edge Ee while in SVC: state=IDLE after Ee.
  - If the source is still pending, REQ is re-entered at Ee+1.
  - Software must clear the source (e.g. timer CR1 write) before EOI.
- Simultaneous events:
  - ack and withdraw in the same REQ cycle: ack wins, go to SVC.
  - EOI write outside SVC: ignored.
  - cpu_ack outside REQ: ignored.
  - IE/GCR write in the same cycle as the FSM evaluates: the FSM uses pre-write values. The new mask affects pend_q at the next edge.
- rst asserted in any state: all state returns to reset values at that edge. cpu_irq is low the following cycle, and any in-flight service is abandoned.

## Test plan
- Reset, then read all four registers -> IE=0, GCR=0, STAT=0, EOI reads 0; cpu_irq=0, cpu_vec=0.
- IE=0x1, GIE=1, pulse src_irq[0] high and hold -> cpu_irq=1 two cycles after the sampled edge, cpu_vec=0. Assert cpu_ack -> cpu_irq=0, STAT[13:12]=10. Drop src, write EOI -> STAT[13:12]=00, no new request.
- IE=0xF, GIE=1, src_irq=4'b1100 -> cpu_vec=2. Then set src[0]=1 while in REQ -> cpu_vec stays 2. After ack + src[2] cleared + EOI -> next REQ with cpu_vec=0.
- In REQ on source 1, clear IE bit1 (no ack) -> pend_q[1]=0 next edge, FSM returns to IDLE, cpu_irq falls.
- In SVC, write EOI while the source is still high -> REQ re-entered one cycle later with the same vector. Assert rst during REQ -> cpu_irq=0 next cycle and all registers read 0.
- With sel=0 and re=1 -> rdata=0, rdy=0. With sel=1, write STAT -> no register change.

Source files
------------

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: per-source and global masking, fixed lowest-index priority,
// single outstanding request tracked through a CPU acknowledge / EOI handshake.
module irq_ctrl #(
    parameter int unsigned NSRC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sel,
    input  logic            we,
    input  logic            re,
    input  logic [1:0]      addr,
    input  logic [15:0]     wdata,
    output logic [15:0]     rdata,
    output logic            rdy,
    input  logic [NSRC-1:0] src_irq,
    output logic            cpu_irq,
    input  logic            cpu_ack,
    output logic [2:0]      cpu_vec
);

    localparam logic [1:0] ADDR_IE   = 2'd0;
    localparam logic [1:0] ADDR_GCR  = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;
    localparam logic [1:0] ADDR_EOI  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StSvc  = 2'b10
    } state_e;

    state_e          state_q;
    logic [NSRC-1:0] ie_q;
    logic [NSRC-1:0] pend_q;
    logic            gie_q;
    logic [2:0]      cur_q;
    logic            cpu_irq_q;

    logic            bus_wr;
    logic            eoi_wr;
    logic [2:0]      win;
    logic [7:0]      pend_ext;
    logic            cur_pend;
    logic            unused_wdata;

    assign bus_wr       = sel & we;
    assign eoi_wr       = bus_wr && (addr == ADDR_EOI);
    assign rdy          = sel;
    assign cpu_irq      = cpu_irq_q;
    assign cpu_vec      = cur_q;
    assign unused_wdata = ^wdata;

    // Zero-extend so the 3-bit vector can index pend regardless of NSRC.
    assign pend_ext = 8'(pend_q);
    assign cur_pend = pend_ext[cur_q];

    // Lowest set index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        win = 3'd0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                win = 3'(i);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && re) begin
            case (addr)
                ADDR_IE:   rdata[NSRC-1:0] = ie_q;
                ADDR_GCR:  rdata[0] = gie_q;
                ADDR_STAT: begin
                    rdata[NSRC-1:0] = pend_q;
                    rdata[10:8]     = cur_q;
                    rdata[13:12]    = state_q;
                end
                default:   rdata = '0;
            endcase
        end
    end

    // Mask registers and pending capture; pend uses the pre-write IE value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q   <= '0;
            gie_q  <= 1'b0;
            pend_q <= '0;
        end else begin
            pend_q <= src_irq & ie_q;
            if (bus_wr && (addr == ADDR_IE)) begin
                ie_q <= wdata[NSRC-1:0];
            end
            if (bus_wr && (addr == ADDR_GCR)) begin
                gie_q <= wdata[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cur_q     <= 3'd0;
            cpu_irq_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gie_q && (|pend_q)) begin
                        state_q   <= StReq;
                        cur_q     <= win;
                        cpu_irq_q <= 1'b1;
                    end
                end
                StReq: begin
                    // Acknowledge takes precedence over a withdrawn or masked request.
                    if (cpu_ack) begin
                        state_q   <= StSvc;
                        cpu_irq_q <= 1'b0;
                    end else if (!gie_q || !cur_pend) begin
                        state_q   <= StIdle;
                        cpu_irq_q <= 1'b0;
                    end
                end
                StSvc: begin
                    if (eoi_wr) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cpu_irq_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: bus reads push expected values, a negedge monitor pops and checks.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic        rdy;
    logic [3:0]  src_irq = 4'd0;
    logic        cpu_irq;
    logic        cpu_ack = 1'b0;
    logic [2:0]  cpu_vec;

    typedef struct {
        string       name;
        logic [15:0] rdata;
        logic        rdy;
        logic        irq;
        logic [2:0]  vec;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    logic done = 1'b0;
    logic drained = 1'b0;

    irq_ctrl #(.NSRC(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .we      (we),
        .re      (re),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rdy     (rdy),
        .src_irq (src_irq),
        .cpu_irq (cpu_irq),
        .cpu_ack (cpu_ack),
        .cpu_vec (cpu_vec)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (re) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: read seen with no expected entry");
            end else begin
                mon_e = sb_q.pop_front();
                if (rdata !== mon_e.rdata || rdy !== mon_e.rdy || cpu_irq !== mon_e.irq ||
                    cpu_vec !== mon_e.vec) begin
                    n_fail++;
                    $display("FAIL %s: got rdata=%h rdy=%b irq=%b vec=%0d, expected rdata=%h rdy=%b irq=%b vec=%0d",
                             mon_e.name, rdata, rdy, cpu_irq, cpu_vec,
                             mon_e.rdata, mon_e.rdy, mon_e.irq, mon_e.vec);
                end
            end
        end else if (done && !drained) begin
            n_checks++;
            if (sb_q.size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
            end
            drained = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic s, input logic [1:0] a, input logic [15:0] exp_d,
                      input logic exp_irq, input logic [2:0] exp_vec, input string name);
        exp_t e;
        sel = s;
        re = 1'b1;
        we = 1'b0;
        addr = a;
        e.name = name;
        e.rdata = exp_d;
        e.rdy = s;
        e.irq = exp_irq;
        e.vec = exp_vec;
        sb_q.push_back(e);
        tick();
        sel = 1'b0;
        re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        sel = 1'b1;
        we = 1'b1;
        addr = a;
        wdata = d;
        tick();
        sel = 1'b0;
        we = 1'b0;
    endtask

    task automatic ack_pulse();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        rd(1, 2'd0, 16'h0000, 0, 0, "rst_ie");
        rd(1, 2'd1, 16'h0000, 0, 0, "rst_gcr");
        rd(1, 2'd2, 16'h0000, 0, 0, "rst_stat");
        rd(1, 2'd3, 16'h0000, 0, 0, "rst_eoi");

        // Single source 0: two-cycle latency, ack, EOI
        wr(2'd0, 16'h0001);
        wr(2'd1, 16'h0001);
        src_irq = 4'b0001;
        rd(1, 2'd2, 16'h0000, 0, 0, "t2_before_e0");
        rd(1, 2'd2, 16'h0001, 0, 0, "t2_pend_after_e0");
        rd(1, 2'd2, 16'h1001, 1, 0, "t2_req_after_e1");
        ack_pulse();
        rd(1, 2'd2, 16'h2001, 0, 0, "t2_svc");
        src_irq = 4'b0000;
        tick();
        rd(1, 2'd2, 16'h2000, 0, 0, "t2_svc_src_low");
        wr(2'd3, 16'h0000);
        rd(1, 2'd2, 16'h0000, 0, 0, "t2_idle_after_eoi");
        tick();
        rd(1, 2'd2, 16'h0000, 0, 0, "t2_no_new_req");

        // Priority and no preemption in REQ
        wr(2'd0, 16'h000F);
        src_irq = 4'b1100;
        tick();
        tick();
        rd(1, 2'd2, 16'h120C, 1, 2, "t3_req_vec2");
        src_irq = 4'b1101;
        tick();
        rd(1, 2'd2, 16'h120D, 1, 2, "t3_no_preempt");
        ack_pulse();
        rd(1, 2'd2, 16'h220D, 0, 2, "t3_svc_vec2");
        src_irq = 4'b0001;
        tick();
        wr(2'd3, 16'h0000);
        rd(1, 2'd2, 16'h0201, 0, 2, "t3_idle_vec_kept");
        rd(1, 2'd2, 16'h1001, 1, 0, "t3_next_req_vec0");
        ack_pulse();
        src_irq = 4'b0000;
        wr(2'd3, 16'h0000);
        rd(1, 2'd2, 16'h0000, 0, 0, "t3_cleanup_idle");

        // Masking a pending request in REQ withdraws it
        src_irq = 4'b0010;
        tick();
        tick();
        rd(1, 2'd2, 16'h1102, 1, 1, "t4_req_vec1");
        wr(2'd0, 16'h000D);
        rd(1, 2'd2, 16'h1102, 1, 1, "t4_after_ie_write");
        rd(1, 2'd2, 16'h1100, 1, 1, "t4_pend_cleared");
        rd(1, 2'd2, 16'h0100, 0, 1, "t4_back_idle");

        // EOI with source still high re-enters REQ; then reset during REQ
        wr(2'd0, 16'h000F);
        tick();
        tick();
        rd(1, 2'd2, 16'h1102, 1, 1, "t5_req");
        ack_pulse();
        rd(1, 2'd2, 16'h2102, 0, 1, "t5_svc");
        wr(2'd3, 16'h0000);
        rd(1, 2'd2, 16'h0102, 0, 1, "t5_idle_after_eoi");
        rd(1, 2'd2, 16'h1102, 1, 1, "t5_reenter_req");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(1, 2'd0, 16'h0000, 0, 0, "t5_rst_ie");
        rd(1, 2'd1, 16'h0000, 0, 0, "t5_rst_gcr");
        rd(1, 2'd2, 16'h0000, 0, 0, "t5_rst_stat");

        // Unselected read, write to STAT ignored
        src_irq = 4'b0000;
        rd(0, 2'd0, 16'h0000, 0, 0, "t6_unselected");
        wr(2'd2, 16'hFFFF);
        rd(1, 2'd0, 16'h0000, 0, 0, "t6_ie_unchanged");
        rd(1, 2'd1, 16'h0000, 0, 0, "t6_gcr_unchanged");
        rd(1, 2'd2, 16'h0000, 0, 0, "t6_stat_unchanged");

        // GIE=0 blocks the request; ack outside REQ ignored
        wr(2'd0, 16'h0001);
        src_irq = 4'b0001;
        tick();
        tick();
        rd(1, 2'd2, 16'h0001, 0, 0, "t7_gie_off_idle");
        ack_pulse();
        rd(1, 2'd2, 16'h0001, 0, 0, "t7_ack_in_idle");

        done = 1'b1;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
